// File: rtl/spi_pkg.sv
// Shared constants for the SPI-slave framing controller: FSM encodings,
// header R/W polarity and chip-select levels.
package spi_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_ADDR     = 3'd1;
  localparam state_t ST_WRITE    = 3'd2;
  localparam state_t ST_RD_FETCH = 3'd3;
  localparam state_t ST_READ     = 3'd4;
  localparam state_t ST_DONE     = 3'd5;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic CS_ON    = 1'b0;
  localparam logic CS_OFF   = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// Memory-side bus of the SPI-slave controller.
interface spi_slave_ctrl_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  // dm_we and rd_req are single-cycle strobes qualified by addr (and wdata
  // for writes); rdata must be valid exactly one clk after rd_req.
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              dm_we;
  logic              rd_req;
  logic [DATA_W-1:0] rdata;

  modport master (output addr, wdata, dm_we, rd_req, input rdata);
  modport slave  (input addr, wdata, dm_we, rd_req, output rdata);
endinterface

// File: rtl/spi_input_sync.sv
// Multi-flop synchroniser with rise/fall pulses derived from the last two
// synchronised samples.
module spi_input_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI-slave (mode 0) framing controller: address + R/W header, then write
// words or read words, with optional address auto-increment for bursts.
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int BURST_EN    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cs,
  input  logic                    sclk,
  input  logic                    mosi,
  output logic                    miso,
  output logic                    miso_oe,
  output logic                    busy,
  output logic                    frame_err,
  output logic [2:0]              dbg_state,
  spi_slave_ctrl_if.master        mem
);

  localparam int SH_W  = max_int(ADDR_W + 1, DATA_W);
  localparam int CNT_W = $clog2(SH_W + 1);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
  logic sclk_unused_level, cs_unused_level, mosi_unused_rise, mosi_unused_fall;

  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .d_i(sclk),
    .level_o(sclk_unused_level), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CS_OFF)) u_sync_cs (
    .clk(clk), .reset(reset), .d_i(cs),
    .level_o(cs_unused_level), .rise_o(cs_rise), .fall_o(cs_fall)
  );
  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .d_i(mosi),
    .level_o(mosi_s), .rise_o(mosi_unused_rise), .fall_o(mosi_unused_fall)
  );

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, tx_q, tx_d;
  logic [SH_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic              miso_q, miso_d, dm_we_q, dm_we_d, rd_req_q, rd_req_d, ferr_q, ferr_d;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    tx_d     = tx_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    miso_d   = miso_q;
    dm_we_d  = 1'b0;
    rd_req_d = 1'b0;
    ferr_d   = 1'b0;

    // Burst writes advance the address the clk after the strobe, so the
    // memory sees addr/wdata stable while dm_we is high.
    if (dm_we_q && (BURST_EN != 0)) addr_d = addr_q + ADDR_W'(1);

    if (cs_rise && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      bitcnt_d = '0;
      ferr_d   = (state_q == ST_ADDR) ||
                 (((state_q == ST_WRITE) || (state_q == ST_READ)) && (bitcnt_q != '0));
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_d  = ST_ADDR;
            bitcnt_d = '0;
          end
        end
        ST_ADDR: begin
          if (sclk_rise) begin
            shift_d  = {shift_q[SH_W-2:0], mosi_s};
            bitcnt_d = bitcnt_q + CNT_W'(1);
            if (bitcnt_q == CNT_W'(ADDR_W)) begin
              addr_d   = shift_q[ADDR_W-1:0];
              bitcnt_d = '0;
              if (mosi_s == RW_READ) begin
                state_d  = ST_RD_FETCH;
                rd_req_d = 1'b1;
              end else begin
                state_d  = ST_WRITE;
              end
            end
          end
        end
        ST_WRITE: begin
          if (sclk_rise) begin
            shift_d  = {shift_q[SH_W-2:0], mosi_s};
            bitcnt_d = bitcnt_q + CNT_W'(1);
            if (bitcnt_q == CNT_W'(DATA_W - 1)) begin
              wdata_d  = {shift_q[DATA_W-2:0], mosi_s};
              dm_we_d  = 1'b1;
              bitcnt_d = '0;
              if (BURST_EN == 0) state_d = ST_DONE;
            end
          end
        end
        ST_RD_FETCH: begin
          // First cycle carries rd_req; rdata is valid on the second.
          if (!rd_req_q) begin
            tx_d    = mem.rdata;
            miso_d  = mem.rdata[DATA_W-1];
            state_d = ST_READ;
          end
        end
        ST_READ: begin
          if (sclk_fall) begin
            tx_d     = {tx_q[DATA_W-2:0], 1'b0};
            miso_d   = tx_q[DATA_W-2];
            bitcnt_d = bitcnt_q + CNT_W'(1);
            if (bitcnt_q == CNT_W'(DATA_W - 1)) begin
              bitcnt_d = '0;
              if (BURST_EN != 0) begin
                addr_d   = addr_q + ADDR_W'(1);
                rd_req_d = 1'b1;
                state_d  = ST_RD_FETCH;
              end else begin
                state_d  = ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      tx_q     <= '0;
      shift_q  <= '0;
      bitcnt_q <= '0;
      miso_q   <= 1'b0;
      dm_we_q  <= 1'b0;
      rd_req_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      tx_q     <= tx_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      miso_q   <= miso_d;
      dm_we_q  <= dm_we_d;
      rd_req_q <= rd_req_d;
      ferr_q   <= ferr_d;
    end
  end

  assign mem.addr   = addr_q;
  assign mem.wdata  = wdata_q;
  assign mem.dm_we  = dm_we_q;
  assign mem.rd_req = rd_req_q;
  assign miso       = miso_q;
  assign miso_oe    = (state_q == ST_READ);
  assign busy       = (state_q != ST_IDLE);
  assign frame_err  = ferr_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Bench for spi_slave_ctrl: a burst and a single-word instance share the SPI
// pins; a frame-level model predicts memory strobes, errors and miso bits.
module tb_spi_slave_ctrl;
  import spi_pkg::*;

  localparam int AW   = 7;
  localparam int DW   = 8;
  localparam int EW   = 2 + AW + DW;
  localparam int HALF = 10;
  localparam int MSZ  = 1 << AW;

  localparam logic [1:0] K_WE  = 2'd1;
  localparam logic [1:0] K_RD  = 2'd2;
  localparam logic [1:0] K_ERR = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset, cs, sclk, mosi, load;
  always #5 clk = ~clk;

  logic       miso_b, oe_b, busy_b, ferr_b;
  logic       miso_n, oe_n, busy_n, ferr_n;
  logic [2:0] state_b, state_n;

  spi_slave_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) mem_b ();
  spi_slave_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) mem_n ();

  spi_slave_ctrl #(.ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(2), .BURST_EN(1)) u_burst (
    .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi),
    .miso(miso_b), .miso_oe(oe_b), .busy(busy_b), .frame_err(ferr_b),
    .dbg_state(state_b), .mem(mem_b)
  );
  spi_slave_ctrl #(.ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(2), .BURST_EN(0)) u_single (
    .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi),
    .miso(miso_n), .miso_oe(oe_n), .busy(busy_n), .frame_err(ferr_n),
    .dbg_state(state_n), .mem(mem_n)
  );

  // Memory environment answering each DUT.
  logic [DW-1:0] init_mem [MSZ];
  logic [DW-1:0] ram_b [MSZ];
  logic [DW-1:0] ram_n [MSZ];

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < MSZ; i++) begin
        ram_b[i] <= init_mem[i];
        ram_n[i] <= init_mem[i];
      end
    end else begin
      if (mem_b.dm_we)  ram_b[mem_b.addr] <= mem_b.wdata;
      if (mem_b.rd_req) mem_b.rdata <= ram_b[mem_b.addr];
      if (mem_n.dm_we)  ram_n[mem_n.addr] <= mem_n.wdata;
      if (mem_n.rd_req) mem_n.rdata <= ram_n[mem_n.addr];
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0] model_b [MSZ];
  logic [DW-1:0] model_n [MSZ];
  logic [EW-1:0] exp_b_q[$];
  logic [EW-1:0] exp_n_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] ev(input logic [1:0] k, input logic [AW-1:0] a,
                                       input logic [DW-1:0] d);
    return {k, a, d};
  endfunction

  function automatic logic [EW-1:0] observe(input logic we, input logic rd,
                                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (we) return ev(K_WE, a, d);
    if (rd) return ev(K_RD, a, '0);
    return ev(K_ERR, '0, '0);
  endfunction

  task automatic push_exp(input bit burst, input logic [EW-1:0] e);
    if (burst) exp_b_q.push_back(e);
    else       exp_n_q.push_back(e);
  endtask

  task automatic model_write(input bit burst, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (burst) model_b[a] = d;
    else       model_n[a] = d;
    push_exp(burst, ev(K_WE, a, d));
  endtask

  // Monitors: every strobe/error pulse must match the head of the queue.
  always @(negedge clk) begin
    if (mem_b.dm_we || mem_b.rd_req || ferr_b) begin
      logic [EW-1:0] got, exp;
      got = observe(mem_b.dm_we, mem_b.rd_req, mem_b.addr, mem_b.wdata);
      checks++;
      if (exp_b_q.size() == 0) begin
        errors++;
        $display("FAIL burst_event: got %0h, expected no event (t=%0t)", got, $time);
      end else begin
        exp = exp_b_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL burst_event: got %0h, expected %0h (t=%0t)", got, exp, $time);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mem_n.dm_we || mem_n.rd_req || ferr_n) begin
      logic [EW-1:0] got, exp;
      got = observe(mem_n.dm_we, mem_n.rd_req, mem_n.addr, mem_n.wdata);
      checks++;
      if (exp_n_q.size() == 0) begin
        errors++;
        $display("FAIL single_event: got %0h, expected no event (t=%0t)", got, $time);
      end else begin
        exp = exp_n_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL single_event: got %0h, expected %0h (t=%0t)", got, exp, $time);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves sclk high so the caller can sample miso before the falling edge.
  task automatic sclk_high(input logic b);
    mosi = b;
    wait_clks(HALF);
    sclk = 1'b1;
    wait_clks(HALF);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_addr_b"}, 32'(mem_b.addr), 0);
    chk({tag, "_wdata_b"}, 32'(mem_b.wdata), 0);
    chk({tag, "_strobes_b"}, {29'd0, mem_b.dm_we, mem_b.rd_req, ferr_b}, 0);
    chk({tag, "_miso_b"}, {29'd0, miso_b, oe_b, busy_b}, 0);
    chk({tag, "_state_b"}, 32'(state_b), 32'(ST_IDLE));
    chk({tag, "_addr_n"}, 32'(mem_n.addr), 0);
    chk({tag, "_wdata_n"}, 32'(mem_n.wdata), 0);
    chk({tag, "_strobes_n"}, {29'd0, mem_n.dm_we, mem_n.rd_req, ferr_n}, 0);
    chk({tag, "_miso_n"}, {29'd0, miso_n, oe_n, busy_n}, 0);
    chk({tag, "_state_n"}, 32'(state_n), 32'(ST_IDLE));
  endtask

  // One full frame of n sclk cycles; expectations come from the frame rules.
  task automatic run_frame(input logic [AW-1:0] a, input logic rw, input int n,
                           input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                           input logic [DW-1:0] w2, input logic [DW-1:0] w3);
    logic [DW-1:0] words [4];
    logic [AW-1:0] ak;
    logic          b;
    logic          exp_bit;
    int            nd, full, rem, d, j;
    bit            burst;
    words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;

    for (int m = 0; m < 2; m++) begin
      burst = (m == 0);
      if (n < AW + 1) begin
        push_exp(burst, ev(K_ERR, '0, '0));
      end else if (rw == RW_WRITE) begin
        nd = n - AW - 1; full = nd / DW; rem = nd % DW;
        if (burst) begin
          for (int k = 0; k < full; k++) model_write(1'b1, a + AW'(k), words[k]);
          if (rem != 0) push_exp(1'b1, ev(K_ERR, '0, '0));
        end else if (full >= 1) begin
          model_write(1'b0, a, words[0]);
        end else if (rem != 0) begin
          push_exp(1'b0, ev(K_ERR, '0, '0));
        end
      end else begin
        nd = n - AW; full = nd / DW; rem = nd % DW;
        push_exp(burst, ev(K_RD, a, '0));
        if (burst) begin
          for (int k = 1; k <= full; k++) push_exp(1'b1, ev(K_RD, a + AW'(k), '0));
          if (rem != 0) push_exp(1'b1, ev(K_ERR, '0, '0));
        end else if (full == 0 && rem != 0) begin
          push_exp(1'b0, ev(K_ERR, '0, '0));
        end
      end
    end

    cs = CS_ON;
    for (int i = 0; i < n; i++) begin
      if (i < AW)       b = a[AW-1-i];
      else if (i == AW) b = rw;
      else begin
        d = i - AW - 1;
        b = words[d / DW][DW-1-(d % DW)];
      end
      sclk_high(b);
      if (rw == RW_READ && i >= AW) begin
        j  = i - AW;
        ak = a + AW'(j / DW);
        exp_bit = model_b[ak][DW-1-(j % DW)];
        chk("miso_oe_burst", 32'(oe_b), 1);
        chk("miso_burst", 32'(miso_b), 32'(exp_bit));
        if (j < DW) begin
          exp_bit = model_n[a][DW-1-(j % DW)];
          chk("miso_oe_single", 32'(oe_n), 1);
          chk("miso_single", 32'(miso_n), 32'(exp_bit));
        end else begin
          chk("miso_oe_single_done", 32'(oe_n), 0);
        end
      end
      sclk = 1'b0;
    end
    wait_clks(HALF);
    cs = CS_OFF;
    wait_clks(2 * HALF);
    chk("busy_after_frame", {30'd0, busy_b, busy_n}, 0);
    chk("oe_after_frame", {30'd0, oe_b, oe_n}, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] ra;
    logic          rrw;
    int            rn, sel;

    reset = 1'b1; cs = CS_OFF; sclk = 1'b0; mosi = 1'b0; load = 1'b0;
    for (int i = 0; i < MSZ; i++) init_mem[i] = DW'($urandom);
    init_mem[7'h10] = 8'h3C;
    for (int i = 0; i < MSZ; i++) begin
      model_b[i] = init_mem[i];
      model_n[i] = init_mem[i];
    end
    wait_clks(3);
    chk_outputs_zero("reset");
    load = 1'b1;
    wait_clks(1);
    load = 1'b0;
    reset = 1'b0;
    wait_clks(5);

    run_frame(7'h05, RW_WRITE, 16, 8'hA5, 8'h00, 8'h00, 8'h00);
    run_frame(7'h7F, RW_WRITE, 24, 8'h11, 8'h22, 8'h00, 8'h00);
    run_frame(7'h10, RW_READ, 15, 8'h00, 8'h00, 8'h00, 8'h00);
    run_frame(7'h2A, RW_WRITE, 12, 8'hC3, 8'h00, 8'h00, 8'h00);
    run_frame(7'h33, RW_WRITE, 24, 8'h5A, 8'h96, 8'h00, 8'h00);

    // Reset in the middle of a write word: no strobes, everything back to 0.
    cs = CS_ON;
    for (int i = 0; i < AW + 5; i++) begin
      sclk_high((i == AW) ? RW_WRITE : 1'(i % 2));
      sclk = 1'b0;
    end
    wait_clks(2);
    reset = 1'b1;
    #1;
    chk_outputs_zero("mid_reset");
    cs = CS_OFF;
    wait_clks(3);
    reset = 1'b0;
    wait_clks(5);
    run_frame(7'h01, RW_WRITE, 16, 8'hFF, 8'h00, 8'h00, 8'h00);

    for (int f = 0; f < 36; f++) begin
      ra  = AW'($urandom_range(0, MSZ - 1));
      rrw = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 3);
      case (sel)
        0:       rn = $urandom_range(1, AW);
        1:       rn = (rrw == RW_READ) ? AW + DW * $urandom_range(1, 3)
                                       : AW + 1 + DW * $urandom_range(1, 3);
        default: rn = AW + 1 + $urandom_range(0, 30);
      endcase
      run_frame(ra, rrw, rn, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
    end

    wait_clks(10);
    chk("pending_burst_events", 32'(exp_b_q.size()), 0);
    chk("pending_single_events", 32'(exp_n_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
